// File: rtl/nn_layer_seq.sv
`default_nettype none
// ============================================================================
// nn_layer_seq : time-multiplexed fully-connected layer, one shared MAC,
//                weights/biases streamed from an external synchronous ROM.
//                Define ACT_RELU_EN for ReLU activation (linear otherwise).
// Revision: 1.0
// ============================================================================
module nn_layer_seq #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 3,
    parameter int AWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*DWIDTH-1:0]   in_data,
    output logic [AWIDTH-1:0]        w_addr,
    input  logic [DWIDTH-1:0]        w_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT*DWIDTH-1:0]  out_data
);

    localparam int ACCW = 2*DWIDTH + 4;
    localparam int KW   = $clog2(N_IN + 1);
    localparam int JW   = $clog2(N_OUT + 1);

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [JW-1:0]              j_q, j_d;
    logic [AWIDTH-1:0]          addr_q, addr_d;
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic [N_IN*DWIDTH-1:0]     x_q, x_d;
    logic [N_OUT*DWIDTH-1:0]    out_q, out_d;
    logic                       ov_q, ov_d;

    logic signed [DWIDTH-1:0]   w_sgn;
    logic signed [DWIDTH-1:0]   x_sel;
    logic signed [2*DWIDTH-1:0] prod;
    logic signed [ACCW-1:0]     bias_ext;
    logic signed [ACCW-1:0]     sum;
    logic signed [ACCW-1:0]     shifted;
    logic [DWIDTH-1:0]          sat;
    logic [DWIDTH-1:0]          act;

    assign w_sgn    = $signed(w_data);
    assign prod     = x_sel * w_sgn;
    assign bias_ext = $signed({{(ACCW-DWIDTH){w_data[DWIDTH-1]}}, w_data}) <<< FRAC;
    assign sum      = acc_q + bias_ext;
    assign shifted  = sum >>> FRAC;

    // ROM data lags the address by one cycle, so MAC step k consumes input k-1.
    always_comb begin
        x_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (k_q == KW'(i + 1)) begin
                x_sel = $signed(x_q[i*DWIDTH +: DWIDTH]);
            end
        end
    end

    always_comb begin
        sat = shifted[DWIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat = {1'b0, {(DWIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(DWIDTH-1){1'b0}}};
        end
    end

`ifdef ACT_RELU_EN
    assign act = sat[DWIDTH-1] ? '0 : sat;
`else
    assign act = sat;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        x_d     = x_q;
        out_d   = out_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    addr_d  = '0;
                    k_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                // Address runs straight through, ending on the next neuron's base.
                addr_d = addr_q + AWIDTH'(1);
                if (k_q != '0) begin
                    acc_d = acc_q + {{4{prod[2*DWIDTH-1]}}, prod};
                end
                if (k_q == KW'(N_IN)) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                for (int j = 0; j < N_OUT; j++) begin
                    if (j_q == JW'(j)) begin
                        out_d[j*DWIDTH +: DWIDTH] = act;
                    end
                end
                acc_d = '0;
                if (j_q == JW'(N_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + JW'(1);
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                // First DONE cycle registers out_valid; handshake only once it is visible.
                if (!ov_q) begin
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign w_addr    = addr_q;
    assign out_valid = ov_q;
    assign out_data  = out_q;

endmodule
`default_nettype wire
